disp_arbiter: RTL

Shares the board's four-digit seven-segment display between two independent requesters. Each requester offers a 16-bit hex value over a valid/ready handshake. The block grants requesters round-robin and holds each accepted value on the display for a fixed dwell time. It drives the four per-digit segment patterns that feed the time-multiplexing display mux, applying hex-to-segment encoding, leading-zero blanking and an owner indicator.

---
 rtl/disp_arbiter_pkg.sv | 18 +
 rtl/disp_arbiter_if.sv | 12 +
 rtl/disp_arbiter_hex_to_sseg.sv | 9 +
 rtl/disp_arbiter.sv | 93 +++++++++
 4 files changed

// File: rtl/disp_arbiter_pkg.sv
// Shared constants for the two-requester seven-segment display arbiter:
// segment encodings, FSM states and requester ids.
package disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low gfedcba with dp (bit7) off; element n is the glyph for nibble n.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic {IDLE, SHOW} state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/disp_arbiter_if.sv
// Valid/ready request bundle for the two display requesters.
interface disp_arbiter_if;
  logic        a_valid;
  logic [15:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [15:0] b_data;
  logic        b_ready;

  modport master (output a_valid, a_data, b_valid, b_data, input a_ready, b_ready);
  modport slave  (input a_valid, a_data, b_valid, b_data, output a_ready, b_ready);
endinterface

// File: rtl/disp_arbiter_hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment pattern, dp off.
module hex_to_sseg
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);
  assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/disp_arbiter.sv
// Round-robin arbiter sharing a four-digit seven-segment display between two
// requesters; each accepted value is held for DWELL cycles before the next grant.
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int DWELL = 50_000_000
) (
  input  logic            clk,
  input  logic            reset,
  disp_arbiter_if.slave   req,
  input  logic            blank_lz,
  output logic [7:0]      seg3,
  output logic [7:0]      seg2,
  output logic [7:0]      seg1,
  output logic [7:0]      seg0,
  output logic            owner,
  output logic            busy
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  state_t        state, state_nxt;
  logic          prio;
  logic [CW-1:0] cnt;
  logic          grant_a, grant_b, xfer, sel;
  logic [15:0]   data;
  logic [7:0]    enc3, enc2, enc1, enc0;
  logic          z3, z2, z1;

  assign grant_a = req.a_valid & (~req.b_valid | (prio == REQ_A));
  assign grant_b = req.b_valid & (~req.a_valid | (prio == REQ_B));
  assign req.a_ready = (state == IDLE) & req.a_valid & grant_a;
  assign req.b_ready = (state == IDLE) & req.b_valid & grant_b;
  assign xfer = req.a_ready | req.b_ready;
  assign sel  = req.b_ready ? REQ_B : REQ_A;
  assign data = (sel == REQ_B) ? req.b_data : req.a_data;
  assign busy = (state == SHOW);

  hex_to_sseg u_hex3 (.nibble(data[15:12]), .seg(enc3));
  hex_to_sseg u_hex2 (.nibble(data[11:8]),  .seg(enc2));
  hex_to_sseg u_hex1 (.nibble(data[7:4]),   .seg(enc1));
  hex_to_sseg u_hex0 (.nibble(data[3:0]),   .seg(enc0));

  // A digit blanks only when it and every more-significant nibble are zero.
  assign z3 = blank_lz & (data[15:12] == 4'h0);
  assign z2 = z3 & (data[11:8] == 4'h0);
  assign z1 = z2 & (data[7:4] == 4'h0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = SHOW;
      SHOW:    if (cnt == CNT_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Priority always moves to the side that was not just served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      prio <= REQ_A;
    end else if (xfer) begin
      cnt  <= '0;
      prio <= ~sel;
    end else if (state == SHOW) begin
      cnt  <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg3  <= SEG_BLANK;
      seg2  <= SEG_BLANK;
      seg1  <= SEG_BLANK;
      seg0  <= SEG_BLANK;
      owner <= REQ_A;
    end else if (xfer) begin
      seg3  <= z3 ? SEG_BLANK : enc3;
      seg2  <= z2 ? SEG_BLANK : enc2;
      seg1  <= z1 ? SEG_BLANK : enc1;
      seg0  <= {enc0[7] & (sel == REQ_A), enc0[6:0]};
      owner <= sel;
    end
  end

endmodule
